// File: rtl/mips_main_control.sv
// mips_main_control -- multicycle main control FSM for the 32-bit MIPS datapath.
//
// Sequences each instruction through fetch / decode / execute / memory /
// writeback and drives every datapath enable plus the 2-bit alu_op for the
// ALU function decoder. The memory handshake (mem_ready) is honoured only in
// FETCH, MEMRD and MEMWR. Retired instructions are counted in instret.
//
// Build option: define MIPS_CTRL_ADDI_EN to add the ADDIEX/ADDIWB states for
// opcode 001000; without it that opcode is reported through illegal_op.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   opcode, zero          instr[31:26] and the ALU zero flag
//   mem_ready             memory completes the current access this cycle
//   i_or_d .. pc_src      datapath mux selects / write enables (Moore)
//   pc_en                 pc_write | (branch & zero)
//   illegal_op            one-cycle pulse in DECODE on an unsupported opcode
//   state                 current state encoding (debug)
//   instret               retired-instruction count, wraps

module mips_main_control #(
  parameter int PERF_CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [5:0]            opcode,
  input  logic                  zero,
  input  logic                  mem_ready,
  output logic                  i_or_d,
  output logic                  ir_write,
  output logic                  mem_write,
  output logic                  reg_write,
  output logic                  reg_dst,
  output logic                  mem_to_reg,
  output logic                  alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [1:0]            alu_op,
  output logic [1:0]            pc_src,
  output logic                  pc_en,
  output logic                  illegal_op,
  output logic [3:0]            state,
  output logic [PERF_CNT_W-1:0] instret
);

  localparam logic [3:0] FETCH   = 4'd0;
  localparam logic [3:0] DECODE  = 4'd1;
  localparam logic [3:0] MEMADR  = 4'd2;
  localparam logic [3:0] MEMRD   = 4'd3;
  localparam logic [3:0] MEMWB   = 4'd4;
  localparam logic [3:0] MEMWR   = 4'd5;
  localparam logic [3:0] EXECUTE = 4'd6;
  localparam logic [3:0] ALUWB   = 4'd7;
  localparam logic [3:0] BEQ     = 4'd8;
  localparam logic [3:0] ADDIEX  = 4'd9;
  localparam logic [3:0] ADDIWB  = 4'd10;
  localparam logic [3:0] JUMP    = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  logic [3:0] next_state;
  logic       pc_write;
  logic       branch;
  logic       retire;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= next_state;
  end

  // Retired-instruction counter; retire is high only on the last cycle of
  // an instruction, so each instruction is counted exactly once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       instret <= '0;
    else if (retire) instret <= instret + PERF_CNT_W'(1);
  end

  // Next-state logic
  always_comb begin
    next_state = FETCH;
    case (state)
      FETCH:   next_state = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_RTYPE:     next_state = EXECUTE;
          OP_BEQ:       next_state = BEQ;
          OP_J:         next_state = JUMP;
`ifdef MIPS_CTRL_ADDI_EN
          OP_ADDI:      next_state = ADDIEX;
`endif
          default:      next_state = FETCH;
        endcase
      end
      MEMADR:  next_state = (opcode == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   next_state = mem_ready ? MEMWB : MEMRD;
      MEMWB:   next_state = FETCH;
      MEMWR:   next_state = mem_ready ? FETCH : MEMWR;
      EXECUTE: next_state = ALUWB;
      ALUWB:   next_state = FETCH;
      BEQ:     next_state = FETCH;
`ifdef MIPS_CTRL_ADDI_EN
      ADDIEX:  next_state = ADDIWB;
      ADDIWB:  next_state = FETCH;
`endif
      JUMP:    next_state = FETCH;
      default: next_state = FETCH;
    endcase
  end

  // Output logic: Moore per state, with mem_ready/zero/opcode qualifiers
  always_comb begin
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_src     = 2'b00;
    pc_write   = 1'b0;
    branch     = 1'b0;
    illegal_op = 1'b0;
    retire     = 1'b0;
    case (state)
      FETCH: begin
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J: illegal_op = 1'b0;
`ifdef MIPS_CTRL_ADDI_EN
          OP_ADDI:                              illegal_op = 1'b0;
`endif
          default:                              illegal_op = 1'b1;
        endcase
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEMRD:   i_or_d = 1'b1;
      MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        retire     = 1'b1;
      end
      MEMWR: begin
        i_or_d    = 1'b1;
        mem_write = 1'b1;
        retire    = mem_ready;
      end
      EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      BEQ: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        branch    = 1'b1;
        retire    = 1'b1;
      end
`ifdef MIPS_CTRL_ADDI_EN
      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      ADDIWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
`endif
      JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
        retire   = 1'b1;
      end
      default: ;
    endcase
  end

  assign pc_en = pc_write | (branch & zero);

endmodule

// File: tb/tb_mips_main_control.sv
// Scoreboard bench for mips_main_control: the driver pushes the hand-computed
// expected state/control word/instret for each cycle; a negedge monitor pops
// and compares. The counter is built 3 bits wide so wrap-around is exercised.

module tb_mips_main_control;

  localparam int W = 3;

  logic         clk, reset;
  logic [5:0]   opcode;
  logic         zero, mem_ready;
  logic         i_or_d, ir_write, mem_write, reg_write, reg_dst, mem_to_reg;
  logic         alu_src_a, pc_en, illegal_op;
  logic [1:0]   alu_src_b, alu_op, pc_src;
  logic [3:0]   state;
  logic [W-1:0] instret;

  mips_main_control #(.PERF_CNT_W(W)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .i_or_d(i_or_d), .ir_write(ir_write), .mem_write(mem_write), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src), .pc_en(pc_en),
    .illegal_op(illegal_op), .state(state), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {i_or_d, ir_write, mem_write, reg_write, reg_dst, mem_to_reg, alu_src_a,
  //  alu_src_b[2], alu_op[2], pc_src[2], pc_en, illegal_op}
  logic [14:0] act_ctl;
  assign act_ctl = {i_or_d, ir_write, mem_write, reg_write, reg_dst, mem_to_reg,
                    alu_src_a, alu_src_b, alu_op, pc_src, pc_en, illegal_op};

  localparam logic [14:0] C_F1  = 15'b0_1_0_0_0_0_0_01_00_00_1_0;
  localparam logic [14:0] C_F0  = 15'b0_0_0_0_0_0_0_01_00_00_0_0;
  localparam logic [14:0] C_DEC = 15'b0_0_0_0_0_0_0_11_00_00_0_0;
  localparam logic [14:0] C_ILL = 15'b0_0_0_0_0_0_0_11_00_00_0_1;
  localparam logic [14:0] C_MA  = 15'b0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [14:0] C_MR  = 15'b1_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [14:0] C_MWB = 15'b0_0_0_1_0_1_0_00_00_00_0_0;
  localparam logic [14:0] C_MWR = 15'b1_0_1_0_0_0_0_00_00_00_0_0;
  localparam logic [14:0] C_EX  = 15'b0_0_0_0_0_0_1_00_10_00_0_0;
  localparam logic [14:0] C_AWB = 15'b0_0_0_1_1_0_0_00_00_00_0_0;
  localparam logic [14:0] C_BT  = 15'b0_0_0_0_0_0_1_00_01_01_1_0;
  localparam logic [14:0] C_BN  = 15'b0_0_0_0_0_0_1_00_01_01_0_0;
  localparam logic [14:0] C_J   = 15'b0_0_0_0_0_0_0_00_00_10_1_0;
`ifdef MIPS_CTRL_ADDI_EN
  localparam logic [14:0] C_IWB = 15'b0_0_0_1_0_0_0_00_00_00_0_0;
`endif

  localparam logic [3:0] S_F = 4'd0, S_D = 4'd1, S_MA = 4'd2, S_MR = 4'd3,
                         S_MWB = 4'd4, S_MWR = 4'd5, S_EX = 4'd6, S_AWB = 4'd7,
                         S_BEQ = 4'd8, S_J = 4'd11;
`ifdef MIPS_CTRL_ADDI_EN
  localparam logic [3:0] S_AEX = 4'd9, S_AWB2 = 4'd10;
`endif

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000,
                         OP_BAD = 6'b111111;

  typedef struct {
    int          id;
    logic [3:0]  st;
    logic [14:0] ctl;
    logic [W-1:0] ret;
  } exp_t;

  exp_t q[$];
  int   nvec = 0;
  int   nbad = 0;
  int   vid  = 0;
  int   ret  = 0;
  logic [31:0] ret_v;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: one expected entry per cycle, compared mid-cycle
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk($sformatf("v%0d state", e.id),   32'(state),   32'(e.st));
      chk($sformatf("v%0d ctl", e.id),     32'(act_ctl), 32'(e.ctl));
      chk($sformatf("v%0d instret", e.id), 32'(instret), 32'(e.ret));
    end
  end

  // Apply inputs for one cycle and record what the DUT must show in it
  task automatic cyc(input logic [5:0] op, input logic z, input logic mr,
                     input logic [3:0] st, input logic [14:0] c);
    exp_t e;
    @(posedge clk);
    #1;
    opcode = op; zero = z; mem_ready = mr;
    ret_v = 32'(ret);
    e.id = vid; e.st = st; e.ctl = c; e.ret = ret_v[W-1:0];
    q.push_back(e);
    vid++;
  endtask

  task automatic rtype();
    cyc(OP_R, 1'b0, 1'b1, S_F,   C_F1);
    cyc(OP_R, 1'b0, 1'b1, S_D,   C_DEC);
    cyc(OP_R, 1'b0, 1'b1, S_EX,  C_EX);
    cyc(OP_R, 1'b0, 1'b1, S_AWB, C_AWB);
    ret++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; opcode = '0; zero = 1'b0; mem_ready = 1'b0;
    #1 reset = 1'b1;
    #2;
    chk("reset state",   32'(state),   32'd0);
    chk("reset instret", 32'(instret), 32'd0);
    chk("reset ctl",     32'(act_ctl), 32'(C_F0));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // R-type with one FETCH stall
    cyc(OP_R, 1'b0, 1'b0, S_F, C_F0);
    rtype();

    // lw: mem_ready ignored in DECODE/MEMADR/MEMWB, 3 stall cycles in MEMRD
    cyc(OP_LW, 1'b0, 1'b1, S_F,   C_F1);
    cyc(OP_LW, 1'b0, 1'b0, S_D,   C_DEC);
    cyc(OP_LW, 1'b0, 1'b0, S_MA,  C_MA);
    cyc(OP_LW, 1'b0, 1'b0, S_MR,  C_MR);
    cyc(OP_LW, 1'b0, 1'b0, S_MR,  C_MR);
    cyc(OP_LW, 1'b0, 1'b0, S_MR,  C_MR);
    cyc(OP_LW, 1'b0, 1'b1, S_MR,  C_MR);
    cyc(OP_LW, 1'b0, 1'b0, S_MWB, C_MWB);
    ret++;

    // beq taken then not taken
    cyc(OP_BEQ, 1'b1, 1'b1, S_F,   C_F1);
    cyc(OP_BEQ, 1'b1, 1'b1, S_D,   C_DEC);
    cyc(OP_BEQ, 1'b1, 1'b1, S_BEQ, C_BT);
    ret++;
    cyc(OP_BEQ, 1'b0, 1'b1, S_F,   C_F1);
    cyc(OP_BEQ, 1'b0, 1'b1, S_D,   C_DEC);
    cyc(OP_BEQ, 1'b0, 1'b1, S_BEQ, C_BN);
    ret++;

    // sw with mem_ready delayed 2 cycles
    cyc(OP_SW, 1'b0, 1'b1, S_F,   C_F1);
    cyc(OP_SW, 1'b0, 1'b1, S_D,   C_DEC);
    cyc(OP_SW, 1'b0, 1'b1, S_MA,  C_MA);
    cyc(OP_SW, 1'b0, 1'b0, S_MWR, C_MWR);
    cyc(OP_SW, 1'b0, 1'b0, S_MWR, C_MWR);
    cyc(OP_SW, 1'b0, 1'b1, S_MWR, C_MWR);
    ret++;

    // illegal opcode: single pulse, no count
    cyc(OP_BAD, 1'b0, 1'b1, S_F, C_F1);
    cyc(OP_BAD, 1'b0, 1'b1, S_D, C_ILL);

    // addi
    cyc(OP_ADDI, 1'b0, 1'b1, S_F, C_F1);
`ifdef MIPS_CTRL_ADDI_EN
    cyc(OP_ADDI, 1'b0, 1'b1, S_D,    C_DEC);
    cyc(OP_ADDI, 1'b0, 1'b1, S_AEX,  C_MA);
    cyc(OP_ADDI, 1'b0, 1'b1, S_AWB2, C_IWB);
    ret++;
`else
    cyc(OP_ADDI, 1'b0, 1'b1, S_D, C_ILL);
`endif

    // jump
    cyc(OP_J, 1'b0, 1'b1, S_F, C_F1);
    cyc(OP_J, 1'b0, 1'b1, S_D, C_DEC);
    cyc(OP_J, 1'b0, 1'b1, S_J, C_J);
    ret++;

    // counter passes through all-ones and wraps
    for (int i = 0; i < 3; i++) rtype();

    // sw aborted by asynchronous reset while mem_write is high
    cyc(OP_SW, 1'b0, 1'b1, S_F,   C_F1);
    cyc(OP_SW, 1'b0, 1'b1, S_D,   C_DEC);
    cyc(OP_SW, 1'b0, 1'b1, S_MA,  C_MA);
    cyc(OP_SW, 1'b0, 1'b0, S_MWR, C_MWR);
    @(posedge clk);
    #1 mem_ready = 1'b0;
    #1;
    chk("pre-abort mem_write", 32'(mem_write), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("abort state",     32'(state),     32'd0);
    chk("abort mem_write", 32'(mem_write), 32'd0);
    chk("abort instret",   32'(instret),   32'd0);
    chk("abort ctl",       32'(act_ctl),   32'(C_F0));
    #1 mem_ready = 1'b1;
    #1;
    chk("in-reset ctl mr=1", 32'(act_ctl), 32'(C_F1));
    @(negedge clk);
    mem_ready = 1'b0;
    reset = 1'b0;
    ret = 0;

    cyc(OP_J, 1'b0, 1'b1, S_F, C_F1);
    cyc(OP_J, 1'b0, 1'b1, S_D, C_DEC);
    cyc(OP_J, 1'b0, 1'b1, S_J, C_J);
    ret++;
    cyc(OP_R, 1'b0, 1'b0, S_F, C_F0);

    @(negedge clk);
    #1;
    chk("scoreboard drained", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule

// File: doc/mips_main_control.md
Name: mips_main_control

Overview:
- Multicycle main control FSM for the 32-bit MIPS datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives all datapath enables and the 2-bit alu_op consumed by the ALU function decoder.
- Handles a simple memory handshake and counts retired instructions.

Parameters:
- PERF_CNT_W, 32, width of the retired-instruction counter (wraps modulo 2^PERF_CNT_W).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- opcode  in  6  instr[31:26] from the instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- i_or_d  out  1  0 = PC address, 1 = ALU-out address
- ir_write  out  1  load instruction register
- mem_write  out  1  memory write request
- reg_write  out  1  register file write enable
- reg_dst  out  1  1 = rd, 0 = rt
- mem_to_reg  out  1  1 = memory data, 0 = ALU-out
- alu_src_a  out  1  0 = PC, 1 = reg A
- alu_src_b  out  2  00 = reg B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
- alu_op  out  2  00 = add, 01 = subtract, 10 = use funct
- pc_src  out  2  00 = ALU result, 01 = ALU-out, 10 = jump target
- pc_en  out  1  pc_write | (branch & zero)
- illegal_op  out  1  one-cycle pulse on an unsupported opcode
- state  out  4  current state encoding (debug)
- instret  out  PERF_CNT_W  retired-instruction count

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BEQ=8, ADDIEX=9, ADDIWB=10, JUMP=11.
- Codes 12-15 are unreachable; if entered, go to FETCH with no outputs asserted.
- Outputs are combinational (Moore) from state, plus mem_ready/zero where noted. Every output not listed for a state is 0.
- FETCH:
  - Drives i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
  - ir_write = pc_write = mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE on mem_ready=1.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Next state by opcode:
  - 100011 or 101011 -> MEMADR
  - 000000 -> EXECUTE
  - 000100 -> BEQ
  - 000010 -> JUMP
  - 001000 -> ADDIEX (see optional feature)
  - any other opcode -> illegal_op=1 this cycle, next state FETCH
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next MEMRD if opcode=100011, else MEMWR.
- MEMRD: i_or_d=1. Holds until mem_ready=1, then MEMWB.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1. Next FETCH.
- MEMWR: i_or_d=1, mem_write=1, held high until mem_ready=1. Next FETCH on mem_ready=1.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10. Next ALUWB.
- ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1. Next FETCH.
- BEQ: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, branch=1. Next FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00. Next ADDIWB.
- ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1. Next FETCH.
- JUMP: pc_src=10, pc_write=1. Next FETCH.
- Branch decision: pc_en = pc_write | (branch & zero), evaluated combinationally in the BEQ cycle.
- instret:
  - Increments by 1 on each clock edge that leaves a terminal state: MEMWB, ALUWB, BEQ (taken or not), ADDIWB, JUMP, or MEMWR with mem_ready=1.
  - Illegal opcodes do not count.
  - Wraps from all-ones to 0.
- Reset:
  - Asynchronous; state=FETCH and instret=0 immediately, mid-instruction included.
  - During and after reset, outputs take FETCH values: ir_write/pc_en follow mem_ready, all others as listed for FETCH.
  - An aborted MEMWR drops mem_write immediately.
- mem_ready is ignored in every state except FETCH, MEMRD and MEMWR.

Optional Feature:
- Macro MIPS_CTRL_ADDI_EN.
- Defined: opcode 001000 decodes to ADDIEX -> ADDIWB as above.
- Undefined: ADDIEX and ADDIWB are not built; opcode 001000 is illegal (illegal_op pulse in DECODE, return to FETCH, no count).

Test Plan:
- Reset asserted mid-MEMWR with mem_write=1 -> state=0, mem_write=0 and instret=0 asynchronously, before the next clk edge.
- R-type (opcode 000000), mem_ready=1 always -> states 0,1,6,7,0; alu_op=10 in EXECUTE; reg_write=1, reg_dst=1 in ALUWB; instret +1.
- lw (100011) with mem_ready low 3 cycles in MEMRD -> stays in state 3 for 4 cycles; MEMWB has mem_to_reg=1, reg_write=1; total 5 states + 3 stall cycles.
- beq (000100), zero=1 then zero=0 on a repeat -> pc_en=1, pc_src=01, alu_op=01 in BEQ for the first; pc_en=0 for the second; instret +2.
- sw (101011) with mem_ready delayed 2 cycles -> mem_write held high 3 cycles, then FETCH; reg_write never asserted.
- Opcode 111111 -> illegal_op=1 for exactly one cycle in DECODE, back to FETCH, instret unchanged. Opcode 001000 -> ADDIWB with reg_write=1 if MIPS_CTRL_ADDI_EN is defined, else illegal_op.
